// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL reset/lock sequencer: holds pll_rst, waits for a stable lock, then releases sys_rst.
// Optional macro PLL_SEQ_RETRY_LIMIT_EN adds a latched FAIL state after MAX_RETRY consecutive lock timeouts.
module pll_rst_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 27000,
    parameter int STABLE_CYCLES = 2700,
    parameter int MAX_RETRY     = 4
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       clk_ready,
    output logic [7:0] relock_cnt,
    output logic       pll_fail
);
    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int RW        = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY - 1);

    typedef enum logic [2:0] {S_HOLD, S_WAIT, S_STABLE, S_RUN, S_FAIL} state_t;
`else
    typedef enum logic [2:0] {S_HOLD, S_WAIT, S_STABLE, S_RUN} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    relock_q, relock_d;
    logic          sync1_q, sync2_q;
    logic          lock;

    assign lock = sync2_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q  <= S_HOLD;
            cnt_q    <= '0;
            retry_q  <= '0;
            relock_q <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            relock_q <= relock_d;
            sync1_q  <= pll_locked;
            sync2_q  <= sync1_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        case (state_q)
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                // A lock arriving on the timeout cycle takes priority over the retry.
                if (lock) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_LAST) begin
                    cnt_d = '0;
                    if (retry_q != {RW{1'b1}}) begin
                        retry_d = retry_q + RW'(1);
                    end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                    state_d = (retry_q == RETRY_LAST) ? S_FAIL : S_HOLD;
`else
                    state_d = S_HOLD;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STABLE: begin
                if (!lock) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                if (!lock) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    if (relock_q != 8'hFF) begin
                        relock_d = relock_q + 8'd1;
                    end
                end
            end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
            S_FAIL: begin
                state_d = S_FAIL;
            end
`endif
            default: begin
                state_d = S_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    assign sys_rst    = (state_q != S_RUN);
    assign clk_ready  = (state_q == S_RUN);
    assign relock_cnt = relock_q;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    assign pll_rst    = (state_q == S_HOLD) || (state_q == S_FAIL);
    assign pll_fail   = (state_q == S_FAIL);
`else
    assign pll_rst    = (state_q == S_HOLD);
    assign pll_fail   = 1'b0;
`endif

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16, giving the number of refclk cycles pll_rst is held per attempt (minimum 1).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 27000, giving the number of refclk cycles to wait for lock per attempt (1 ms at 27 MHz).
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 2700, giving the number of consecutive synchronized lock-high cycles required before release (100 us).
REQ-004 The block SHALL have parameter MAX_RETRY, default 4, giving the number of consecutive timeouts before failure; it is used only under the configuration macro.
REQ-005 Port refclk, input, 1 bit: the single clock, 27.0 MHz, which is the same reference that feeds the PLL.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port pll_locked, input, 1 bit: the PLL locked output, asynchronous to refclk.
REQ-008 Port pll_rst, output, 1 bit: the PLL reset request.
REQ-009 Port sys_rst, output, 1 bit: reset to the SDRAM clock-domain logic, active-high.
REQ-010 Port clk_ready, output, 1 bit: high while the PLL outputs are stable and usable.
REQ-011 Port relock_cnt, output, 8 bits: saturating count of lock losses seen in RUN.
REQ-012 Port pll_fail, output, 1 bit: latched PLL failure flag.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer clocked by refclk; "lock" below means the synchronized value, which lags the pin by 2 cycles.
REQ-014 The FSM SHALL have states HOLD, WAIT, STABLE, RUN and FAIL; FAIL exists only under the configuration macro.
REQ-015 All outputs SHALL be decoded from registers only, with no combinational path from pll_locked or rst to any output.
REQ-016 Output decoding SHALL be:
- pll_rst = 1 in HOLD and FAIL
- sys_rst = 1 in every state except RUN
- clk_ready = 1 only in RUN
REQ-017 HOLD SHALL last exactly RST_CYCLES cycles, then go to WAIT with the cycle counter cleared.
REQ-018 In WAIT:
- lock = 1 -> go to STABLE, counter cleared
- LOCK_TIMEOUT cycles elapse without lock -> timeout, retry counter increments, go to HOLD
REQ-019 In STABLE:
- lock = 0 on any cycle -> go to WAIT with the counter cleared; the retry counter is unchanged
- lock = 1 for STABLE_CYCLES consecutive cycles -> go to RUN
REQ-020 Entering RUN SHALL clear the retry counter.
REQ-021 In RUN, lock = 0 SHALL cause the following on the next edge:
- go to HOLD
- relock_cnt increments, saturating at 255
REQ-022 sys_rst SHALL assert and clk_ready SHALL deassert on the same edge that leaves RUN.
REQ-023 If a WAIT timeout and a lock rise occur in the same cycle, lock SHALL win and the FSM goes to STABLE.
REQ-024 Counter widths SHALL be ceil(log2(max parameter + 1)) bits, and no counter SHALL wrap.

Reset
REQ-025 With rst high at a refclk edge, the following SHALL be loaded:
- state = HOLD
- cycle counter = 0, retry counter = 0
- both synchronizer flops = 0
- relock_cnt = 0, pll_fail = 0
REQ-026 While in reset the outputs SHALL be pll_rst = 1, sys_rst = 1, clk_ready = 0.
REQ-027 rst asserted in any state, including mid-STABLE, RUN or FAIL, SHALL take effect on the next edge.
REQ-028 After rst is released, HOLD SHALL run its full RST_CYCLES.

Configuration
REQ-029 With macro PLL_SEQ_RETRY_LIMIT_EN defined:
- a timeout that brings the retry counter to MAX_RETRY goes to FAIL instead of HOLD
- FAIL drives pll_fail = 1, pll_rst = 1, sys_rst = 1
- FAIL exits only through rst
REQ-030 Without PLL_SEQ_RETRY_LIMIT_EN:
- timeouts always return to HOLD and retry indefinitely
- pll_fail is constant 0
- FAIL logic and MAX_RETRY comparison are not synthesized

Verification
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
REQ-031 Release rst, raise pll_locked 6 cycles later -> pll_rst high for exactly the first 4 cycles; clk_ready rises and sys_rst falls exactly 10 cycles (2 sync + 8 stable) after the pll_locked pin rises.
REQ-032 pll_locked low for 1 cycle at STABLE cycle 5 -> the FSM returns to WAIT; clk_ready rises 10 cycles after pll_locked returns high; the retry counter is unchanged.
REQ-033 pll_locked held 0 -> pll_rst pulses 4 cycles high every 24 cycles; with the macro, the 2nd timeout asserts pll_fail = 1 and holds pll_rst = 1 until rst; without it, pulses continue and pll_fail stays 0.
REQ-034 In RUN, drop pll_locked -> 2 cycles later (after synchronization) clk_ready = 0, sys_rst = 1, pll_rst = 1 for 4 cycles, and relock_cnt goes 0 -> 1.
REQ-035 300 lock-loss/relock cycles -> relock_cnt reads 255 and stays at 255.
REQ-036 Assert rst mid-STABLE and separately in RUN with relock_cnt = 3 -> on the next edge, outputs and counters are at their REQ-025/REQ-026 reset values.
